m_axi_mem_tg: RTL

- Parametrised AXI4 full-protocol master traffic generator and memory checker; successor to the team's single-burst AXI memory master.
- Issues NUM_BURSTS INCR bursts of BURST_LEN beats starting at BASE_ADDR, then reads them back and compares against a deterministic pattern.
- Mode is selectable at run time: write+verify, write-only or verify-only.
- Reports done, sticky error and error count; sits between a test controller/CPU register block and an AXI interconnect slave port.

---
 rtl/m_axi_mem_tg.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/m_axi_mem_tg.sv
// AXI4 master traffic generator and memory checker.
// Writes NUM_BURSTS INCR bursts of a counting pattern starting at BASE_ADDR,
// reads them back, and counts mismatching beats and error responses.
//
// state  | meaning
// IDLE   | waiting for txn_start
// WADDR  | presenting write address of the current burst
// WDATA  | streaming pattern beats of the current burst
// WRESP  | waiting for the write response
// RADDR  | presenting read address of the current burst
// RDATA  | receiving and checking read beats
// FIN    | one-cycle done pulse, then back to IDLE
module m_axi_mem_tg #(
    parameter int                  ID_WIDTH     = 1,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h4000_0000),
    parameter int                  BURST_LEN    = 16,
    parameter int                  NUM_BURSTS   = 4,
    parameter logic [31:0]         PATTERN_SEED = 32'hA5A5_0000
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,
    input  logic                    txn_start,
    input  logic [1:0]              txn_mode,
    output logic                    txn_busy,
    output logic                    txn_done,
    output logic                    txn_error,
    output logic [15:0]             err_count,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int BYTES_PER_BEAT  = DATA_WIDTH / 8;
    localparam int BYTES_PER_BURST = BURST_LEN * BYTES_PER_BEAT;
    localparam int BURST_W         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [7:0]         LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [2:0]         AXI_SIZE   = 3'($clog2(BYTES_PER_BEAT));
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN} state_t;

    state_t              state, state_nxt;
    logic [1:0]          mode_q;
    logic [BURST_W-1:0]  burst_cnt;
    logic [7:0]          beat_cnt;
    logic [15:0]         err_cnt;
    logic                err_flag;
    logic                is_last_beat, is_last_burst;
    logic [31:0]         pattern_word;
    logic [DATA_WIDTH-1:0] pattern;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic                beat_err, err_inc;

    assign is_last_beat  = (beat_cnt == LAST_BEAT);
    assign is_last_burst = (burst_cnt == LAST_BURST);
    assign pattern_word  = PATTERN_SEED + 32'(burst_cnt) * 32'(BURST_LEN) + 32'(beat_cnt);
    assign pattern       = DATA_WIDTH'(pattern_word);
    assign burst_addr    = BASE_ADDR + ADDR_WIDTH'(32'(burst_cnt) * 32'(BYTES_PER_BURST));

    // Read IDs are checked like write IDs: only ID 0 is ever issued.
    assign beat_err = (m_axi_rresp != 2'b00) || (m_axi_rid != '0) ||
                      (m_axi_rdata != pattern) || (m_axi_rlast != is_last_beat);
    assign err_inc  = ((state == WRESP) && m_axi_bvalid &&
                       ((m_axi_bresp != 2'b00) || (m_axi_bid != '0))) ||
                      ((state == RDATA) && m_axi_rvalid && beat_err);

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = burst_addr;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wdata   = pattern;
    assign m_axi_wstrb   = '1;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = burst_addr;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign err_count     = err_cnt;
    assign txn_error     = err_flag;

    // State register; valids are decoded from state so reset drops them at once.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) state <= IDLE;
        else              state <= state_nxt;
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        state_nxt     = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        txn_done      = 1'b0;
        txn_busy      = (state != IDLE) && (state != FIN);
        case (state)
            IDLE: if (txn_start) state_nxt = (txn_mode == 2'd2) ? RADDR : WADDR;
            WADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = WDATA;
            end
            WDATA: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = is_last_beat;
                if (m_axi_wready && is_last_beat) state_nxt = WRESP;
            end
            WRESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (!is_last_burst)        state_nxt = WADDR;
                    else if (mode_q == 2'd1)   state_nxt = FIN;
                    else                       state_nxt = RADDR;
                end
            end
            RADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = RDATA;
            end
            RDATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && is_last_beat) state_nxt = is_last_burst ? FIN : RADDR;
            end
            FIN: begin
                txn_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Run bookkeeping: mode latch, burst/beat position, error accounting.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            mode_q    <= 2'd0;
            burst_cnt <= '0;
            beat_cnt  <= 8'd0;
            err_cnt   <= 16'd0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (txn_start) begin
                    mode_q    <= (txn_mode == 2'd3) ? 2'd0 : txn_mode;
                    burst_cnt <= '0;
                    beat_cnt  <= 8'd0;
                    err_cnt   <= 16'd0;
                    err_flag  <= 1'b0;
                end
                WDATA: if (m_axi_wready) beat_cnt <= is_last_beat ? 8'd0 : beat_cnt + 8'd1;
                WRESP: if (m_axi_bvalid) burst_cnt <= is_last_burst ? '0 : burst_cnt + BURST_W'(1);
                RDATA: if (m_axi_rvalid) begin
                    beat_cnt <= is_last_beat ? 8'd0 : beat_cnt + 8'd1;
                    if (is_last_beat) burst_cnt <= is_last_burst ? '0 : burst_cnt + BURST_W'(1);
                end
                FIN: err_flag <= (err_cnt != 16'd0);
                default: ;
            endcase
            if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule
